// File: rtl/fir_pkg.sv
// fir_pkg: sample width and sample type shared by the FIR decimator blocks.
package fir_pkg;
   localparam int SAMPLE_W = 8;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/decim_fifo.sv
// decim_fifo: first-word fall-through FIFO for decimated samples.
// Head reads as 0 while empty; a push into a full FIFO is taken only alongside a pop.
module decim_fifo
   import fir_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clr,
   input  logic                      push,
   input  logic                      pop,
   input  sample_t                   din,
   output sample_t                   dout,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    level
);
   localparam int AW = $clog2(DEPTH);
   sample_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty   = level == '0;
   assign full    = level == (AW+1)'(DEPTH);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   // Storage needs no reset: empty masks the head.
   always_ff @(posedge clk) begin
      if (do_push & ~clr) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/fir_decimator.sv
// fir_decimator: block-average decimator by 2^DECIM_LOG2 feeding an output FIFO.
// Define FIR_DECIM_ROUND_EN to round half up instead of truncating toward -inf.
module fir_decimator
   import fir_pkg::*;
#(
   parameter int DECIM_LOG2 = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [SAMPLE_W-1:0]           in_sample,
   input  logic                          in_valid,
   input  logic                          clr,
   output logic [SAMPLE_W-1:0]           out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          ovf,
   output logic [$clog2(FIFO_DEPTH):0]   level
);
   localparam int ACC_W = SAMPLE_W + DECIM_LOG2;
   logic [DECIM_LOG2-1:0] phase;
   logic signed [ACC_W-1:0] acc, sum, rnd;
   logic accept, push, pop, full, empty;
   sample_t result, head;
   assign accept = in_valid & ~clr;
   assign push   = accept & (&phase);
   assign pop    = out_ready & ~clr;
   // Phase 0 loads rather than accumulates, so acc never needs clearing between blocks.
   assign sum    = (phase == '0 ? '0 : acc) + ACC_W'(sample_t'(in_sample));
`ifdef FIR_DECIM_ROUND_EN
   localparam int HALF = 1 << (DECIM_LOG2 - 1);
   assign rnd    = sum + ACC_W'(HALF);
`else
   assign rnd    = sum;
`endif
   assign result    = sample_t'(rnd >>> DECIM_LOG2);
   assign out_valid = ~empty;
   assign out_data  = head;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= '0;
         acc   <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         phase <= '0;
         acc   <= '0;
         ovf   <= 1'b0;
      end else begin
         if (accept) begin
            phase <= phase + 1'b1;
            acc   <= push ? '0 : sum;
         end
         if (push & full & ~(out_ready & ~empty)) ovf <= 1'b1;
      end
   end
   decim_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .din   (result),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );
endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: randomized and directed checks of fir_decimator against a queue-based model.
module tb_fir_decimator;
   logic clk = 0, reset = 0, in_valid = 0, clr = 0, out_ready = 0;
   logic [7:0] in_sample = 0;
   logic [7:0] out_data;
   logic out_valid, ovf;
   logic [2:0] level;
   int checks = 0, passed = 0;
   int q[$];
   int blk[$];
   bit m_ovf = 0;
`ifdef FIR_DECIM_ROUND_EN
   localparam int RND = 2;
   localparam int NEG_EXP = -2;
`else
   localparam int RND = 0;
   localparam int NEG_EXP = -3;
`endif

   fir_decimator #(.DECIM_LOG2(2), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid), .clr(clr),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf), .level(level)
   );

   always #5 clk = ~clk;

   function automatic int block_result(int s);
      int t = s + RND;
      return (t >= 0) ? t / 4 : -((-t + 3) / 4);
   endfunction

   task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic c);
      bit pop;
      int s;
      in_valid = v; in_sample = d; out_ready = rdy; clr = c;
      pop = rdy && q.size() > 0;
      @(posedge clk);
      if (c) begin
         q.delete(); blk.delete(); m_ovf = 0;
      end else begin
         if (pop) void'(q.pop_front());
         if (v) begin
            blk.push_back(int'($signed(d)));
            if (blk.size() == 4) begin
               s = blk.sum();
               if (q.size() < 4) q.push_back(block_result(s));
               else m_ovf = 1;
               blk.delete();
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(1, 8'd50, 0, 0);
      reset = 1;
      #1;
      checks++;
      if (out_valid !== 0 || out_data !== 0 || level !== 0 || ovf !== 0)
         $display("FAIL reset: valid/data/level/ovf got %b/%0d/%0d/%b want 0/0/0/0", out_valid, out_data, level, ovf);
      else passed++;
      q.delete(); blk.delete(); m_ovf = 0;
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic test_constant();
      cycle(0, 0, 1, 1);
      for (int i = 0; i < 3; i++) cycle(1, 8'd4, 1, 0);
      checks++;
      if (out_valid !== 0) $display("FAIL const_early: out_valid got %b want 0", out_valid);
      else passed++;
      cycle(1, 8'd4, 1, 0);
      checks++;
      if (out_valid !== 1 || out_data !== 8'd4)
         $display("FAIL const_out: valid/data got %b/%0d want 1/4", out_valid, $signed(out_data));
      else passed++;
      cycle(0, 0, 1, 0);
      checks++;
      if (out_valid !== 0 || out_data !== 0)
         $display("FAIL const_popped: valid/data got %b/%0d want 0/0", out_valid, out_data);
      else passed++;
   endtask

   task automatic test_negative();
      cycle(0, 0, 1, 1);
      for (int i = 1; i <= 4; i++) cycle(1, 8'(-i), 1, 0);
      checks++;
      if (out_valid !== 1 || $signed(out_data) !== 8'(NEG_EXP))
         $display("FAIL negative: valid/data got %b/%0d want 1/%0d", out_valid, $signed(out_data), NEG_EXP);
      else passed++;
   endtask

   task automatic test_extremes();
      cycle(0, 0, 1, 1);
      for (int i = 0; i < 4; i++) cycle(1, 8'd127, 1, 0);
      checks++;
      if (out_valid !== 1 || out_data !== 8'd127)
         $display("FAIL max: valid/data got %b/%0d want 1/127", out_valid, $signed(out_data));
      else passed++;
      for (int i = 0; i < 4; i++) cycle(1, 8'h80, 1, 0);
      checks++;
      if (out_valid !== 1 || out_data !== 8'h80)
         $display("FAIL min: valid/data got %b/%0d want 1/-128", out_valid, $signed(out_data));
      else passed++;
   endtask

   task automatic test_overflow();
      int exp_blk[5];
      cycle(0, 0, 0, 1);
      for (int b = 0; b < 5; b++) begin
         int s = 0;
         for (int i = 0; i < 4; i++) begin
            logic [7:0] d = 8'($urandom);
            s += int'($signed(d));
            cycle(1, d, 0, 0);
         end
         exp_blk[b] = block_result(s);
      end
      checks++;
      if (level !== 3'd4 || ovf !== 1)
         $display("FAIL ovf_full: level/ovf got %0d/%b want 4/1", level, ovf);
      else passed++;
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (out_valid !== 1 || $signed(out_data) !== 8'(exp_blk[b]))
            $display("FAIL ovf_drain%0d: valid/data got %b/%0d want 1/%0d", b, out_valid, $signed(out_data), exp_blk[b]);
         else passed++;
         cycle(0, 0, 1, 0);
      end
      checks++;
      if (out_valid !== 0 || level !== 0 || ovf !== 1)
         $display("FAIL ovf_sticky: valid/level/ovf got %b/%0d/%b want 0/0/1", out_valid, level, ovf);
      else passed++;
      cycle(0, 0, 0, 1);
      checks++;
      if (ovf !== 0) $display("FAIL ovf_clr: ovf got %b want 0", ovf);
      else passed++;
   endtask

   task automatic test_gapped();
      logic [7:0] gs[12];
      logic [7:0] a[3];
      logic [7:0] hold;
      cycle(0, 0, 0, 1);
      foreach (gs[i]) gs[i] = 8'($urandom);
      for (int i = 0; i < 12; i++) cycle(1, gs[i], 0, 0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_valid !== 1 || $signed(out_data) !== 8'(q[0]))
            $display("FAIL contig%0d: valid/data got %b/%0d want 1/%0d", k, out_valid, $signed(out_data), q[0]);
         else passed++;
         a[k] = out_data;
         cycle(0, 0, 1, 0);
      end
      for (int i = 0; i < 12; i++) begin
         cycle(1, gs[i], 0, 0);
         cycle(0, 8'($urandom), 0, 0);
         cycle(0, 8'($urandom), 0, 0);
      end
      hold = out_data;
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 0, 0);
         checks++;
         if (out_valid !== 1 || out_data !== hold)
            $display("FAIL stall%0d: valid/data got %b/%0d want 1/%0d", k, out_valid, $signed(out_data), $signed(hold));
         else passed++;
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_valid !== 1 || out_data !== a[k])
            $display("FAIL gapped%0d: valid/data got %b/%0d want 1/%0d", k, out_valid, $signed(out_data), $signed(a[k]));
         else passed++;
         cycle(0, 0, 1, 0);
      end
   endtask

   task automatic test_random();
      logic exp_v;
      logic [7:0] exp_d;
      cycle(0, 0, 0, 1);
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 60) == 0));
         exp_v = q.size() != 0;
         exp_d = exp_v ? 8'(q[0]) : 8'h00;
         checks++;
         if (out_valid !== exp_v || out_data !== exp_d || level !== 3'(q.size()) || ovf !== m_ovf)
            $display("FAIL rand%0d: valid/data/level/ovf got %b/%0d/%0d/%b want %b/%0d/%0d/%b", n,
                     out_valid, $signed(out_data), level, ovf, exp_v, $signed(exp_d), q.size(), m_ovf);
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      cycle(0, 0, 1, 1);
      cycle(1, 8'd100, 1, 0);
      cycle(1, 8'd100, 1, 0);
      reset = 1;
      #2;
      reset = 0;
      for (int i = 0; i < 4; i++) cycle(1, 8'd8, 1, 0);
      checks++;
      if (out_valid !== 1 || out_data !== 8'd8 || level !== 3'd1)
         $display("FAIL reset_mid: valid/data/level got %b/%0d/%0d want 1/8/1", out_valid, $signed(out_data), level);
      else passed++;
      cycle(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 8'd8, 1, 0);
      cycle(1, 8'd8, 1, 1);
      cycle(0, 0, 1, 0);
      checks++;
      if (out_valid !== 0 || level !== 0)
         $display("FAIL clr_last: valid/level got %b/%0d want 0/0", out_valid, level);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_constant();
      test_negative();
      test_extremes();
      test_overflow();
      test_gapped();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
